div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start_i  input  1  request to begin a divide; sampled only in IDLE.
REQ-004 SHALL have port: signed_i  input  1  1 = signed (div), 0 = unsigned (divu); sampled with start_i.
REQ-005 SHALL have port: opa_i  input  32  dividend; sampled with start_i.
REQ-006 SHALL have port: opb_i  input  32  divisor; sampled with start_i.
REQ-007 SHALL have port: cancel_i  input  1  pipeline flush; aborts any operation in progress.
REQ-008 SHALL have port: stall_o  output  1  request to the hazard unit to freeze the decode/execute stages.
REQ-009 SHALL have port: valid_o  output  1  one-cycle pulse marking result_o valid.
REQ-010 SHALL have port: hilowrite_o  output  2  HI/LO write enables; [1]=HI, [0]=LO.
REQ-011 SHALL have port: result_o  output  64  {HI=remainder, LO=quotient}.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: start_i=1 and cancel_i=0 SHALL latch operands and signed_i, and go to BUSY; if opb_i==0, go to DONE instead.
REQ-014 BUSY SHALL run a radix-2 restoring divide producing one quotient bit per cycle using a 6-bit iteration counter 0..31; after the counter reaches 31, go to DONE.
REQ-015 DONE SHALL last exactly one cycle, assert valid_o=1 and hilowrite_o=2'b11, then return to IDLE.
REQ-016 Latency: start accepted at edge N SHALL give valid_o high in the cycle after edge N+32 (33 cycles); for divide-by-zero, in the cycle after edge N.
REQ-017 stall_o SHALL equal (state==IDLE & start_i & ~cancel_i) | (state==BUSY); it SHALL be low in DONE.
REQ-018 start_i in BUSY or DONE SHALL be ignored.
REQ-019 cancel_i in any state SHALL force IDLE at the next edge with no valid_o pulse; cancel_i SHALL win over a simultaneous start_i.
REQ-020 Divide by zero SHALL return HI=opa_i and LO=32'hFFFFFFFF.
REQ-021 Signed mode SHALL divide the magnitudes, negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-022 Signed 32'h80000000 / 32'hFFFFFFFF SHALL return LO=32'h80000000 and HI=0; magnitudes SHALL be held in 33 bits.
REQ-023 result_o SHALL hold its last value outside DONE; valid_o and hilowrite_o SHALL be 0 outside DONE.

Reset
REQ-024 rst low SHALL immediately force IDLE, counter=0, result_o=0, valid_o=0, hilowrite_o=0, stall_o=0, including mid-operation.
REQ-025 After rst is released, the first start_i SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro DIV_SIGNED_EN defined SHALL honour signed_i per REQ-021/REQ-022.
REQ-027 With DIV_SIGNED_EN undefined, signed_i SHALL be ignored, all divides SHALL be unsigned, and the sign-fixup logic SHALL be absent.

Verification
REQ-028 Unsigned 100/7 -> valid_o 33 cycles after start, LO=14, HI=2, hilowrite_o=2'b11, stall_o high for 33 cycles.
REQ-029 Signed -7/2 (32'hFFFFFFF9, 2) with DIV_SIGNED_EN -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; without the macro -> LO=32'h7FFFFFFC, HI=1.
REQ-030 Divisor 0, dividend 32'h1234 -> valid_o on the next cycle, HI=32'h1234, LO=32'hFFFFFFFF, stall_o high for 1 cycle.
REQ-031 cancel_i at iteration 10 -> IDLE next cycle, stall_o low, no valid_o; a new 9/3 start then gives LO=3, HI=0.
REQ-032 rst low at iteration 20 -> all outputs 0 at once; start_i asserted together with cancel_i in IDLE -> no stall_o, stays IDLE.
REQ-033 Signed 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0; start_i pulsed during BUSY -> no effect on the result.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit radix-2 restoring divider with IDLE/BUSY/DONE control and hazard stall.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every divide is unsigned.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        cancel_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [1:0]  hilowrite_o,
  output logic [63:0] result_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  quo, rem, quo_step, rem_step, q_fin, r_fin;
  logic [W:0]    den, mag_a, mag_b, shifted;
  logic [W+1:0]  diff;
  logic          accept, div_zero, ge, last_iter;
  logic          unused_bits;

  assign accept    = (state == IDLE) & start_i & ~cancel_i;
  assign div_zero  = (opb_i == '0);
  assign last_iter = (count == LAST);
  assign stall_o   = rst & (accept | (state == BUSY));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted  = {rem, quo[W-1]};
  assign diff     = {1'b0, shifted} - {1'b0, den};
  assign ge       = ~diff[W+1];
  assign rem_step = ge ? diff[W-1:0] : shifted[W-1:0];
  assign quo_step = {quo[W-2:0], ge};

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b, neg_q, neg_r;

  assign neg_a = signed_i & opa_i[W-1];
  assign neg_b = signed_i & opb_i[W-1];
  // 33-bit magnitudes so that -2^31 negates without overflow.
  assign mag_a = neg_a ? ({(W+1){1'b0}} - {opa_i[W-1], opa_i}) : {1'b0, opa_i};
  assign mag_b = neg_b ? ({(W+1){1'b0}} - {opb_i[W-1], opb_i}) : {1'b0, opb_i};
  assign q_fin = neg_q ? (W'(0) - quo_step) : quo_step;
  assign r_fin = neg_r ? (W'(0) - rem_step) : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end
  end
`else
  assign mag_a = {1'b0, opa_i};
  assign mag_b = {1'b0, opb_i};
  assign q_fin = quo_step;
  assign r_fin = rem_step;
`endif

  assign unused_bits = ^{signed_i, mag_a[W], diff[W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel_i) state_nxt = IDLE;
  end

  // Datapath and registered result/strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      quo         <= '0;
      rem         <= '0;
      den         <= '0;
      result_o    <= '0;
      valid_o     <= 1'b0;
      hilowrite_o <= '0;
    end else begin
      valid_o     <= (state_nxt == DONE);
      hilowrite_o <= {2{state_nxt == DONE}};
      if (accept) begin
        count <= '0;
        quo   <= mag_a[W-1:0];
        rem   <= '0;
        den   <= mag_b;
        if (div_zero) result_o <= {opa_i, {W{1'b1}}};
      end else if ((state == BUSY) && !cancel_i) begin
        count <= count + CW'(1);
        quo   <= quo_step;
        rem   <= rem_step;
        if (last_iter) result_o <= {r_fin, q_fin};
      end
    end
  end

endmodule
